// File: rtl/graph_aggregator.sv
// Edge-driven graph aggregation: each accepted edge adds FM_WM rows into a per-node accumulator
// array (fm[src] into acc[dst], and fm[dst] into acc[src] when symmetric), with optional self-loop pass.
module graph_aggregator #(
  parameter  int NUM_OF_NODES   = 6,
  parameter  int WEIGHT_COLS    = 3,
  parameter  int DOT_PROD_WIDTH = 16,
  parameter  int MAX_EDGES      = 16,
  parameter  int INDEX_BASE     = 1,
  parameter  int SYMMETRIC      = 1,
  parameter  int SELF_LOOP      = 0,
  parameter  int SATURATE       = 1,
  localparam int NBW            = $clog2(NUM_OF_NODES + 1),
  localparam int EW             = $clog2(MAX_EDGES + 1),
  localparam int RW             = WEIGHT_COLS * DOT_PROD_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [EW-1:0]  num_edges,
  input  logic           edge_valid,
  input  logic [NBW-1:0] edge_src,
  input  logic [NBW-1:0] edge_dst,
  output logic           edge_ready,
  output logic [NBW-1:0] fm_rd_row,
  input  logic [RW-1:0]  fm_rd_data,
  input  logic [NBW-1:0] out_rd_row,
  output logic [RW-1:0]  out_rd_data,
  output logic [EW-1:0]  edge_count,
  output logic           busy,
  output logic           done,
  output logic           err_index
);
  localparam int W = DOT_PROD_WIDTH;
  localparam logic [NBW-1:0] LAST_ROW = NBW'(NUM_OF_NODES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_EDGE, UPD_DST, UPD_SRC, SELF, DONE} state_t;

  state_t         state_q, after_s;
  logic [RW-1:0]  acc_q [NUM_OF_NODES];
  logic [EW-1:0]  num_edges_q, edge_count_q;
  logic [NBW-1:0] src_q, dst_q, row_q, fm_row_q;
  logic           bad_q, same_q, ready_q, busy_q, done_q, err_q;
  logic           edge_ok_s;

  function automatic logic idx_ok(input logic [NBW-1:0] raw);
    logic [31:0] r;
    r = 32'(raw);
    return (r >= 32'(INDEX_BASE)) && ((r - 32'(INDEX_BASE)) < 32'(NUM_OF_NODES));
  endfunction

  function automatic logic [NBW-1:0] to_idx(input logic [NBW-1:0] raw);
    logic [31:0] r;
    r = 32'(raw) - 32'(INDEX_BASE);
    return r[NBW-1:0];
  endfunction

  // Element-wise signed add; overflow is detected from the extra sign bit of the widened sum.
  function automatic logic [RW-1:0] row_add(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW-1:0] r;
    logic [W:0]    s;
    r = '0;
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      s = {a[c*W+W-1], a[c*W +: W]} + {b[c*W+W-1], b[c*W +: W]};
      if ((SATURATE != 0) && (s[W] != s[W-1])) begin
        r[c*W +: W] = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        r[c*W +: W] = s[W-1:0];
      end
    end
    return r;
  endfunction

  assign edge_ok_s = idx_ok(edge_src) && idx_ok(edge_dst);

  // Where a finished clear or edge update leads next.
  always_comb begin
    after_s = DONE;
    if (edge_count_q < num_edges_q) begin
      after_s = WAIT_EDGE;
    end else if (SELF_LOOP != 0) begin
      after_s = SELF;
    end else begin
      after_s = DONE;
    end
  end

  // Control FSM with registered outputs and the accumulator array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      num_edges_q  <= '0;
      edge_count_q <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      row_q        <= '0;
      fm_row_q     <= '0;
      bad_q        <= 1'b0;
      same_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      for (int n = 0; n < NUM_OF_NODES; n++) acc_q[n] <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= CLEAR;
            num_edges_q  <= num_edges;
            edge_count_q <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            row_q        <= '0;
          end
        end
        CLEAR: begin
          acc_q[row_q] <= '0;
          if (row_q == LAST_ROW) begin
            state_q <= after_s;
            ready_q <= (after_s == WAIT_EDGE);
            busy_q  <= (after_s != DONE);
            done_q  <= (after_s == DONE);
            row_q   <= '0;
          end else begin
            row_q <= row_q + NBW'(1);
          end
        end
        WAIT_EDGE: begin
          if (edge_valid && ready_q) begin
            edge_count_q <= edge_count_q + EW'(1);
            src_q        <= to_idx(edge_src);
            dst_q        <= to_idx(edge_dst);
            bad_q        <= !edge_ok_s;
            same_q       <= (edge_src == edge_dst);
            err_q        <= err_q | !edge_ok_s;
            ready_q      <= 1'b0;
            fm_row_q     <= edge_ok_s ? to_idx(edge_src) : '0;
            state_q      <= UPD_DST;
          end
        end
        UPD_DST: begin
          if (!bad_q) acc_q[dst_q] <= row_add(acc_q[dst_q], fm_rd_data);
          if ((SYMMETRIC != 0) && !same_q) begin
            state_q  <= UPD_SRC;
            fm_row_q <= bad_q ? '0 : dst_q;
          end else begin
            state_q  <= after_s;
            ready_q  <= (after_s == WAIT_EDGE);
            busy_q   <= (after_s != DONE);
            done_q   <= (after_s == DONE);
            fm_row_q <= '0;
          end
        end
        UPD_SRC: begin
          if (!bad_q) acc_q[src_q] <= row_add(acc_q[src_q], fm_rd_data);
          state_q  <= after_s;
          ready_q  <= (after_s == WAIT_EDGE);
          busy_q   <= (after_s != DONE);
          done_q   <= (after_s == DONE);
          fm_row_q <= '0;
        end
        SELF: begin
          acc_q[row_q] <= row_add(acc_q[row_q], fm_rd_data);
          if (row_q == LAST_ROW) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            row_q    <= '0;
            fm_row_q <= '0;
          end else begin
            row_q    <= row_q + NBW'(1);
            fm_row_q <= row_q + NBW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_rd_data = (out_rd_row < NBW'(NUM_OF_NODES)) ? acc_q[out_rd_row] : '0;
  assign edge_ready  = ready_q;
  assign fm_rd_row   = fm_row_q;
  assign edge_count  = edge_count_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_index   = err_q;

endmodule
